// File: rtl/svm_cascade_sched_if.sv
// Signal bundle between the cascade scheduler and the pixel source, the pixel/SV
// memories and the decision-function unit. The slave modport is the scheduler side.
interface svm_cascade_sched_if #(
    parameter int XLEN_PIXEL    = 8,
    parameter int NUM_OF_PIXELS = 784,
    parameter int NUM_OF_SV     = 10,
    parameter int NUM_OF_STAGES = 3,
    parameter int MARGIN_W      = 32
);
    localparam int PIX_AW = (NUM_OF_PIXELS > 1) ? $clog2(NUM_OF_PIXELS) : 1;
    localparam int SV_AW  = (NUM_OF_SV > 1) ? $clog2(NUM_OF_SV) : 1;
    localparam int STG_W  = (NUM_OF_STAGES > 1) ? $clog2(NUM_OF_STAGES) : 1;

    logic                       start;
    logic                       pix_valid;
    logic [XLEN_PIXEL-1:0]      pix_data;
    logic                       pix_ready;
    logic                       we;
    logic [PIX_AW-1:0]          wr_addr;
    logic [XLEN_PIXEL-1:0]      wr_data;
    logic                       re;
    logic [PIX_AW-1:0]          rd_pix_addr;
    logic [SV_AW-1:0]           rd_sv_addr;
    logic [STG_W-1:0]           stage_sel;
    logic                       acc_clr;
    logic                       acc_en;
    logic                       sv_last;
    logic                       decision_funct_en;
    logic                       dec_done;
    logic signed [MARGIN_W-1:0] dec_margin;
    logic                       dec_label;
    logic                       result_valid;
    logic                       result_label;
    logic [STG_W-1:0]           result_stage;
    logic                       busy;
    logic                       timeout;

    modport slave (
        input  start, pix_valid, pix_data, dec_done, dec_margin, dec_label,
        output pix_ready, we, wr_addr, wr_data, re, rd_pix_addr, rd_sv_addr,
               stage_sel, acc_clr, acc_en, sv_last, decision_funct_en,
               result_valid, result_label, result_stage, busy, timeout
    );

    modport master (
        output start, pix_valid, pix_data, dec_done, dec_margin, dec_label,
        input  pix_ready, we, wr_addr, wr_data, re, rd_pix_addr, rd_sv_addr,
               stage_sel, acc_clr, acc_en, sv_last, decision_funct_en,
               result_valid, result_label, result_stage, busy, timeout
    );
endinterface

// File: rtl/svm_cascade_sched.sv
// Per-vector scheduler for the cascaded SVM engine: pixel load, kernel read sequencing,
// decision firing and stage escalation. Define SVM_TIMEOUT_EN to enable the WAIT_DEC watchdog.
module svm_cascade_sched #(
    parameter int          XLEN_PIXEL    = 8,
    parameter int          NUM_OF_PIXELS = 784,
    parameter int          NUM_OF_SV     = 10,
    parameter int          NUM_OF_STAGES = 3,
    parameter int          RD_LAT        = 2,
    parameter int          MARGIN_W      = 32,
    parameter int unsigned THRESH        = 1000,
    parameter int unsigned TIMEOUT_CYC   = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    svm_cascade_sched_if.slave    bus
);
    localparam int PIX_AW = (NUM_OF_PIXELS > 1) ? $clog2(NUM_OF_PIXELS) : 1;
    localparam int SV_AW  = (NUM_OF_SV > 1) ? $clog2(NUM_OF_SV) : 1;
    localparam int STG_W  = (NUM_OF_STAGES > 1) ? $clog2(NUM_OF_STAGES) : 1;
    localparam int DR_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int WD_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [PIX_AW-1:0] PIX_LAST = PIX_AW'(NUM_OF_PIXELS - 1);
    localparam logic [SV_AW-1:0]  SV_LAST  = SV_AW'(NUM_OF_SV - 1);
    localparam logic [STG_W-1:0]  STG_LAST = STG_W'(NUM_OF_STAGES - 1);
    localparam logic [DR_W-1:0]   DR_LAST  = DR_W'(RD_LAT - 1);
    localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
`ifdef SVM_TIMEOUT_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, DECIDE, WAIT_DEC, DONE} state_t;

    state_t                state, state_nxt;
    logic [PIX_AW-1:0]     pix_cnt;
    logic [SV_AW-1:0]      sv_cnt;
    logic [STG_W-1:0]      stage;
    logic [DR_W-1:0]       drain_cnt;
    logic [WD_W-1:0]       wd_cnt;
    logic [XLEN_PIXEL-1:0] wr_data_q;
    logic                  vld_p  [RD_LAT];
    logic                  clr_p  [RD_LAT];
    logic                  last_p [RD_LAT];

    // Magnitude of a signed margin; the most-negative code clamps to max positive.
    function automatic logic [MARGIN_W-1:0] abs_sat(input logic signed [MARGIN_W-1:0] m);
        logic signed [MARGIN_W-1:0] neg;
        neg = -m;
        if (!m[MARGIN_W-1]) return m;
        if (neg[MARGIN_W-1]) return {1'b0, {(MARGIN_W-1){1'b1}}};
        return neg;
    endfunction

    logic accept, load_last, read_last, drain_last, dec_hit, final_dec, wd_expire;

    assign accept     = (state == LOAD) && bus.pix_valid;
    assign load_last  = accept && (pix_cnt == PIX_LAST);
    assign read_last  = (state == COMPUTE) && (pix_cnt == PIX_LAST) && (sv_cnt == SV_LAST);
    assign drain_last = (state == DRAIN) && (drain_cnt == DR_LAST);
    assign dec_hit    = (state == WAIT_DEC) && bus.dec_done;
    assign final_dec  = (abs_sat(bus.dec_margin) >= MARGIN_W'(THRESH)) || (stage == STG_LAST);
    assign wd_expire  = WD_EN && (state == WAIT_DEC) && !bus.dec_done && (wd_cnt == WD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (bus.start) state_nxt = LOAD;
            LOAD:     if (load_last) state_nxt = COMPUTE;
            COMPUTE:  if (read_last) state_nxt = DRAIN;
            DRAIN:    if (drain_last) state_nxt = DECIDE;
            DECIDE:   state_nxt = WAIT_DEC;
            WAIT_DEC: begin
                if (dec_hit)        state_nxt = final_dec ? DONE : COMPUTE;
                else if (wd_expire) state_nxt = DONE;
            end
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.pix_ready         = 1'b0;
        bus.re                = 1'b0;
        bus.rd_pix_addr       = '0;
        bus.rd_sv_addr        = '0;
        bus.decision_funct_en = 1'b0;
        bus.result_valid      = 1'b0;
        bus.busy              = (state != IDLE);
        case (state)
            LOAD:    bus.pix_ready = 1'b1;
            COMPUTE: begin
                bus.re          = 1'b1;
                bus.rd_pix_addr = pix_cnt;
                bus.rd_sv_addr  = sv_cnt;
            end
            DECIDE:  bus.decision_funct_en = 1'b1;
            DONE:    bus.result_valid = 1'b1;
            default: ;
        endcase
    end

    // Index counters: pixel inner, SV outer; the pixel counter doubles as the load address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_cnt   <= '0;
            sv_cnt    <= '0;
            stage     <= '0;
            drain_cnt <= '0;
            wd_cnt    <= '0;
        end else begin
            if ((state == IDLE) && bus.start) stage <= '0;
            else if (dec_hit && !final_dec)   stage <= stage + 1'b1;
            if (accept)
                pix_cnt <= load_last ? '0 : pix_cnt + 1'b1;
            else if (state == COMPUTE)
                pix_cnt <= (pix_cnt == PIX_LAST) ? '0 : pix_cnt + 1'b1;
            if ((state == COMPUTE) && (pix_cnt == PIX_LAST))
                sv_cnt <= (sv_cnt == SV_LAST) ? '0 : sv_cnt + 1'b1;
            if (state == DRAIN) drain_cnt <= drain_last ? '0 : drain_cnt + 1'b1;
            wd_cnt <= (state == WAIT_DEC) ? wd_cnt + 1'b1 : '0;
        end
    end

    // p0: pixel-buffer write, one cycle after the accepted beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.we      <= 1'b0;
            bus.wr_addr <= '0;
            wr_data_q   <= '0;
        end else begin
            bus.we <= accept;
            if (accept) begin
                bus.wr_addr <= pix_cnt;
                wr_data_q   <= bus.pix_data;
            end
        end
    end
    assign bus.wr_data = wr_data_q;

    // p0..p(RD_LAT-1): read-issue flags delayed to line up with returned memory data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                vld_p[i]  <= 1'b0;
                clr_p[i]  <= 1'b0;
                last_p[i] <= 1'b0;
            end
        end else begin
            vld_p[0]  <= (state == COMPUTE);
            clr_p[0]  <= (state == COMPUTE) && (pix_cnt == '0);
            last_p[0] <= (state == COMPUTE) && (pix_cnt == PIX_LAST);
            for (int i = 1; i < RD_LAT; i++) begin
                vld_p[i]  <= vld_p[i-1];
                clr_p[i]  <= clr_p[i-1];
                last_p[i] <= last_p[i-1];
            end
        end
    end
    assign bus.acc_en    = vld_p[RD_LAT-1];
    assign bus.acc_clr   = clr_p[RD_LAT-1];
    assign bus.sv_last   = last_p[RD_LAT-1];
    assign bus.stage_sel = stage;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.result_label <= 1'b0;
            bus.result_stage <= '0;
            bus.timeout      <= 1'b0;
        end else if (dec_hit && final_dec) begin
            bus.result_label <= bus.dec_label;
            bus.result_stage <= stage;
            bus.timeout      <= 1'b0;
        end else if (wd_expire) begin
            bus.result_label <= 1'b0;
            bus.result_stage <= stage;
            bus.timeout      <= 1'b1;
        end
    end
endmodule

// File: tb/tb_svm_cascade_sched.sv
// Scoreboard bench for svm_cascade_sched: directed runs push expected events into queues,
// a negedge monitor pops and compares whenever the DUT presents an event.
module tb_svm_cascade_sched;
    localparam int NP  = 4;
    localparam int NSV = 2;
    localparam int NST = 2;
    localparam int RDL = 1;
    localparam int TH  = 100;
    localparam int TO  = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    svm_cascade_sched_if #(.XLEN_PIXEL(8), .NUM_OF_PIXELS(NP), .NUM_OF_SV(NSV),
                           .NUM_OF_STAGES(NST), .MARGIN_W(32)) bus ();

    svm_cascade_sched #(.XLEN_PIXEL(8), .NUM_OF_PIXELS(NP), .NUM_OF_SV(NSV),
                        .NUM_OF_STAGES(NST), .RD_LAT(RDL), .MARGIN_W(32),
                        .THRESH(TH), .TIMEOUT_CYC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct { int cyc; int a; int b; int c; } ev_t;
    ev_t wq[$], rq[$], aq[$], dq[$], resq[$];
    int  pass_cnt  = 0;
    int  total_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    endtask

    task automatic unexp(input string name);
        total_cnt++;
        $display("FAIL %s: actual=event required=no event", name);
    endtask

    // Monitor: every DUT event must match the head of its queue.
    always @(negedge clk) begin
        ev_t e;
        if (rst) begin
            if (bus.we) begin
                if (wq.size() == 0) unexp("write");
                else begin
                    e = wq.pop_front();
                    chk("wr_cyc", cyc, e.cyc);
                    chk("wr_addr", int'(bus.wr_addr), e.a);
                    chk("wr_data", int'(bus.wr_data), e.b);
                end
            end
            if (bus.re) begin
                if (rq.size() == 0) unexp("read");
                else begin
                    e = rq.pop_front();
                    chk("rd_cyc", cyc, e.cyc);
                    chk("rd_sv", int'(bus.rd_sv_addr), e.a);
                    chk("rd_pix", int'(bus.rd_pix_addr), e.b);
                    chk("stage_sel", int'(bus.stage_sel), e.c);
                end
            end
            if (bus.acc_en) begin
                if (aq.size() == 0) unexp("acc_en");
                else begin
                    e = aq.pop_front();
                    chk("acc_cyc", cyc, e.cyc);
                    chk("acc_clr", int'(bus.acc_clr), e.a);
                    chk("sv_last", int'(bus.sv_last), e.b);
                end
            end else if (bus.acc_clr || bus.sv_last) unexp("acc_flag_without_en");
            if (bus.decision_funct_en) begin
                if (dq.size() == 0) unexp("decide");
                else begin
                    e = dq.pop_front();
                    chk("dec_cyc", cyc, e.cyc);
                end
            end
            if (bus.result_valid) begin
                if (resq.size() == 0) unexp("result");
                else begin
                    e = resq.pop_front();
                    chk("res_cyc", cyc, e.cyc);
                    chk("res_label", int'(bus.result_label), e.a);
                    chk("res_stage", int'(bus.result_stage), e.b);
                    chk("res_timeout", int'(bus.timeout), e.c);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // vpat bit i = pix_valid in beat i; data byte k = k-th accepted pixel.
    task automatic load_vec(input int npat, input logic [7:0] vpat, input logic [31:0] data,
                            output int last);
        int k;
        k    = 0;
        last = 0;
        for (int i = 0; i < npat; i++) begin
            bus.pix_valid = vpat[i];
            bus.pix_data  = vpat[i] ? data[8*k +: 8] : 8'h5A;
            if (vpat[i]) begin
                wq.push_back('{cyc + 1, k, int'(data[8*k +: 8]), 0});
                k++;
                last = cyc;
            end
            tick();
        end
        bus.pix_valid = 1'b0;
    endtask

    // Reads start at c0 with no bubbles; beat flags follow RDL later; decide after drain.
    task automatic expect_stage(input int c0, input int stg);
        for (int k = 0; k < NSV*NP; k++) begin
            rq.push_back('{c0 + k, k / NP, k % NP, stg});
            aq.push_back('{c0 + RDL + k, int'(k % NP == 0), int'(k % NP == NP - 1), 0});
        end
        dq.push_back('{c0 + NSV*NP + RDL, 0, 0, 0});
    endtask

    task automatic wait_decide();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (bus.decision_funct_en) seen = 1'b1;
        end
        if (!seen) begin
            total_cnt++;
            $display("FAIL decide_wait: actual=no pulse required=pulse within 64 cycles");
        end
    endtask

    // Called right after the decide pulse; dec_done is offered in the first WAIT_DEC cycle.
    task automatic respond(input int margin, input bit label, input int stg, input bit escalate);
        @(posedge clk);
        #1;
        if (escalate) expect_stage(cyc + 1, stg + 1);
        else          resq.push_back('{cyc + 1, int'(label), stg, 0});
        bus.dec_done   = 1'b1;
        bus.dec_margin = margin;
        bus.dec_label  = label;
        tick();
        bus.dec_done = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_ctrl"}, int'({bus.busy, bus.pix_ready, bus.we, bus.re, bus.acc_en,
                                  bus.acc_clr, bus.sv_last, bus.decision_funct_en,
                                  bus.result_valid, bus.timeout}), 0);
        chk({tag, "_wr_addr"}, int'(bus.wr_addr), 0);
        chk({tag, "_wr_data"}, int'(bus.wr_data), 0);
        chk({tag, "_rd_addr"}, int'({bus.rd_sv_addr, bus.rd_pix_addr}), 0);
        chk({tag, "_stage_sel"}, int'(bus.stage_sel), 0);
        chk({tag, "_result"}, int'({bus.result_label, bus.result_stage}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=simulation still running required=finished");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int last;
        bus.start      = 1'b0;
        bus.pix_valid  = 1'b0;
        bus.pix_data   = '0;
        bus.dec_done   = 1'b0;
        bus.dec_margin = '0;
        bus.dec_label  = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_cleared("por");
        tick();
        rst = 1'b1;
        tick();

        // Run A: gappy load, stage0 +50 escalates, stage1 -150 label 1.
        do_start();
        load_vec(6, 8'b0010_1101, 32'h0305_0709, last);
        expect_stage(last + 1, 0);
        wait_decide();
        respond(50, 1'b0, 0, 1'b1);
        wait_decide();
        respond(-150, 1'b1, 1, 1'b0);
        tick();
        chk("a_busy_after", int'(bus.busy), 0);
        chk("a_label_hold", int'(bus.result_label), 1);
        chk("a_stage_hold", int'(bus.result_stage), 1);

        // Reset mid-load: two beats in, then async reset clears everything.
        do_start();
        load_vec(2, 8'b0000_0011, 32'h0000_2211, last);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_cleared("midrst");
        tick();
        rst = 1'b1;

        // Run B: pix_valid in IDLE ignored; |-100| == THRESH retires at stage 0.
        bus.pix_valid = 1'b1;
        bus.pix_data  = 8'hAA;
        repeat (2) tick();
        bus.pix_valid = 1'b0;
        do_start();
        load_vec(4, 8'b0000_1111, 32'h0180_00FF, last);
        expect_stage(last + 1, 0);
        wait_decide();
        respond(-100, 1'b0, 0, 1'b0);
        repeat (2) tick();

        // Run C: start and dec_done during COMPUTE ignored; +99 escalates, final stage retires +10.
        do_start();
        load_vec(4, 8'b0000_1111, 32'h4030_2010, last);
        expect_stage(last + 1, 0);
        bus.start      = 1'b1;
        bus.dec_done   = 1'b1;
        bus.dec_margin = 500;
        bus.dec_label  = 1'b1;
        tick();
        bus.start    = 1'b0;
        bus.dec_done = 1'b0;
        wait_decide();
        respond(99, 1'b1, 0, 1'b1);
        wait_decide();
        respond(10, 1'b0, 1, 1'b0);
        repeat (3) tick();
        chk("c_busy_after", int'(bus.busy), 0);
        chk("c_ready_after", int'(bus.pix_ready), 0);

        // Run D: most-negative margin saturates and retires at stage 0.
        do_start();
        load_vec(4, 8'b0000_1111, 32'h0000_0000, last);
        expect_stage(last + 1, 0);
        wait_decide();
        respond(int'(32'h8000_0000), 1'b1, 0, 1'b0);
        repeat (2) tick();

`ifdef SVM_TIMEOUT_EN
        // Watchdog: no dec_done, result TO cycles after entering WAIT_DEC.
        do_start();
        load_vec(4, 8'b0000_1111, 32'h0403_0201, last);
        expect_stage(last + 1, 0);
        wait_decide();
        resq.push_back('{cyc + 1 + TO, 0, 0, 1});
        repeat (TO + 4) tick();
`endif

        repeat (3) tick();
        chk("wq_left", wq.size(), 0);
        chk("rq_left", rq.size(), 0);
        chk("aq_left", aq.size(), 0);
        chk("dq_left", dq.size(), 0);
        chk("resq_left", resq.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
